// File: rtl/uart_frame_loader_pkg.sv
// Shared definitions for the UART frame loader: sequencer states and frame constants.
// Also imported by the UART transmitter side for the common timeout counter.
package uart_frame_loader_pkg;

  typedef enum logic [2:0] {
    LDR_SYNC     = 3'd0,
    LDR_LO       = 3'd1,
    LDR_HI       = 3'd2,
    LDR_CSUM     = 3'd3,
    LDR_START    = 3'd4,
    LDR_WAIT_FFT = 3'd5
  } ldr_state_t;

  localparam logic [7:0] LDR_SYNC_BYTE_DEF = 8'hA5;
  localparam int         LDR_N_SAMPLES_DEF = 16;
  localparam int         LDR_ADDR_W_DEF    = 4;
  localparam int         LDR_TIMEOUT_DEF   = 1024;
  localparam int         LDR_SAMPLE_W      = 16;

  // States in which a frame is partially received and the inter-byte timeout runs.
  function automatic logic ldr_in_frame(input ldr_state_t s);
    return (s == LDR_LO) || (s == LDR_HI) || (s == LDR_CSUM);
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout: reloads on a strobe, gives a single terminal pulse when
// TIMEOUT enabled cycles elapse without a strobe.
module uart_timeout_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_reload,
  output logic o_expire
);

  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Saturating past TERM keeps the terminal pulse to one cycle if the user stays enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || i_reload) begin
      r_cnt <= '0;
    end else if (r_cnt != SAT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A strobe in the expiry cycle wins over the timeout.
  assign o_expire = i_en && !i_reload && (r_cnt == TERM);

endmodule

// File: rtl/uart_frame_loader.sv
// Frame sequencer between the UART receiver and the FFT sample buffer: header sync,
// byte-pair packing into samples, XOR checksum, FFT start and hold-off while it runs.
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int         N_SAMPLES = LDR_N_SAMPLES_DEF,
  parameter int         ADDR_W    = LDR_ADDR_W_DEF,
  parameter logic [7:0] SYNC_BYTE = LDR_SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = LDR_TIMEOUT_DEF
) (
  input  logic                    clk_uart,
  input  logic                    rst,
  input  logic [7:0]              rx_byte_i,
  input  logic                    rx_valid_i,
  output logic                    rx_enable_o,
  output logic                    wr_en_o,
  output logic [ADDR_W-1:0]       wr_addr_o,
  output logic [LDR_SAMPLE_W-1:0] wr_data_o,
  output logic                    fft_start_o,
  input  logic                    fft_busy_i,
  output logic                    frame_err_o,
  output logic [7:0]              frame_cnt_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

  ldr_state_t r_state, w_state_nxt;
  logic                    r_wait_armed, w_wait_armed_nxt;
  logic [ADDR_W-1:0]       r_idx, w_idx_nxt;
  logic [7:0]              r_csum, w_csum_nxt;
  logic [7:0]              r_lo, w_lo_nxt;
  logic                    r_rx_enable, w_rx_enable_nxt;
  logic                    r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0]       r_wr_addr, w_wr_addr_nxt;
  logic [LDR_SAMPLE_W-1:0] r_wr_data, w_wr_data_nxt;
  logic                    r_fft_start, w_fft_start_nxt;
  logic                    r_frame_err, w_frame_err_nxt;
  logic [7:0]              r_frame_cnt, w_frame_cnt_nxt;

  logic w_byte;
  logic w_in_frame;
  logic w_expire;

  // Bytes offered while reception is disabled are dropped here.
  assign w_byte     = rx_valid_i && r_rx_enable;
  assign w_in_frame = ldr_in_frame(r_state);

  uart_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk_uart),
    .rst      (rst),
    .i_en     (w_in_frame),
    .i_reload (w_byte),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_wait_armed_nxt = r_wait_armed;
    w_idx_nxt        = r_idx;
    w_csum_nxt       = r_csum;
    w_lo_nxt         = r_lo;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_fft_start_nxt  = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_frame_cnt_nxt  = r_frame_cnt;

    unique case (r_state)
      LDR_SYNC: begin
        if (w_byte && (rx_byte_i == SYNC_BYTE)) begin
          w_state_nxt = LDR_LO;
          w_idx_nxt   = '0;
          w_csum_nxt  = 8'h00;
        end
      end

      LDR_LO: begin
        if (w_byte) begin
          w_lo_nxt    = rx_byte_i;
          w_csum_nxt  = r_csum ^ rx_byte_i;
          w_state_nxt = LDR_HI;
        end else if (w_expire) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = LDR_SYNC;
        end
      end

      LDR_HI: begin
        if (w_byte) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_idx;
          w_wr_data_nxt = {rx_byte_i, r_lo};
          w_csum_nxt    = r_csum ^ rx_byte_i;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = LDR_CSUM;
          end else begin
            w_idx_nxt   = r_idx + ADDR_W'(1);
            w_state_nxt = LDR_LO;
          end
        end else if (w_expire) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = LDR_SYNC;
        end
      end

      LDR_CSUM: begin
        if (w_byte) begin
          if (rx_byte_i == r_csum) begin
            // Start pulse and count update land in the START cycle itself.
            w_fft_start_nxt = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
            w_state_nxt     = LDR_START;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = LDR_SYNC;
          end
        end else if (w_expire) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = LDR_SYNC;
        end
      end

      LDR_START: begin
        w_wait_armed_nxt = 1'b0;
        w_state_nxt      = LDR_WAIT_FFT;
      end

      LDR_WAIT_FFT: begin
        // The first cycle gives the FFT time to raise busy before it is trusted.
        if (!r_wait_armed) begin
          w_wait_armed_nxt = 1'b1;
        end else if (!fft_busy_i) begin
          w_wait_armed_nxt = 1'b0;
          w_state_nxt      = LDR_SYNC;
        end
      end

      default: begin
        w_state_nxt = LDR_SYNC;
      end
    endcase

    w_rx_enable_nxt = (w_state_nxt != LDR_START) && (w_state_nxt != LDR_WAIT_FFT);
  end

  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      r_state      <= LDR_SYNC;
      r_wait_armed <= 1'b0;
      r_idx        <= '0;
      r_csum       <= 8'h00;
      r_lo         <= 8'h00;
      r_rx_enable  <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_fft_start  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_armed <= w_wait_armed_nxt;
      r_idx        <= w_idx_nxt;
      r_csum       <= w_csum_nxt;
      r_lo         <= w_lo_nxt;
      r_rx_enable  <= w_rx_enable_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_fft_start  <= w_fft_start_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
    end
  end

  assign rx_enable_o = r_rx_enable;
  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign fft_start_o = r_fft_start;
  assign frame_err_o = r_frame_err;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: a frame-level byte model queues expected
// writes/starts/errors, a negedge monitor pops and compares what the loader emits.
module tb_uart_frame_loader;

  localparam int         N  = 16;
  localparam int         NB = 2 * N;
  localparam int         TO = 1024;
  localparam logic [7:0] SB = 8'hA5;

  localparam int EV_WR    = 0;
  localparam int EV_START = 1;
  localparam int EV_ERR   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        fft_busy = 1'b0;
  logic        rx_enable_o;
  logic        wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        fft_start_o;
  logic        frame_err_o;
  logic [7:0]  frame_cnt_o;

  always #5 clk = ~clk;

  uart_frame_loader #(
    .N_SAMPLES (N),
    .ADDR_W    (4),
    .SYNC_BYTE (SB),
    .TIMEOUT   (TO)
  ) dut (
    .clk_uart    (clk),
    .rst         (rst),
    .rx_byte_i   (rx_byte),
    .rx_valid_i  (rx_valid),
    .rx_enable_o (rx_enable_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .fft_start_o (fft_start_o),
    .fft_busy_i  (fft_busy),
    .frame_err_o (frame_err_o),
    .frame_cnt_o (frame_cnt_o)
  );

  typedef struct {
    int          kind;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         busy_len = 5;
  logic [7:0] pay [NB];

  // Reference model state: hunting for a header, or collecting payload bytes.
  bit         m_in_frame = 1'b0;
  logic [7:0] m_pay[$];
  int         m_good = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void push_ev(input int kind, input logic [3:0] addr, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] x;
    x = 8'h00;
    if (!m_in_frame) begin
      if (b == SB) begin
        m_in_frame = 1'b1;
        m_pay.delete();
      end
    end else if (m_pay.size() < NB) begin
      m_pay.push_back(b);
      if (m_pay.size() % 2 == 0)
        push_ev(EV_WR, 4'(m_pay.size() / 2 - 1), {b, m_pay[m_pay.size() - 2]});
    end else begin
      foreach (m_pay[i]) x = x ^ m_pay[i];
      if (b == x) begin
        push_ev(EV_START, 4'h0, 16'h0);
        m_good++;
      end else begin
        push_ev(EV_ERR, 4'h0, 16'h0);
      end
      m_in_frame = 1'b0;
    end
  endfunction

  function automatic void model_timeout();
    if (m_in_frame) push_ev(EV_ERR, 4'h0, 16'h0);
    m_in_frame = 1'b0;
  endfunction

  function automatic void mon_event(input int kind, input logic [3:0] addr, input logic [15:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none (t=%0t)",
               kind, addr, data, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == EV_WR && kind == EV_WR) begin
        check("wr_addr", 32'(addr), 32'(e.addr));
        check("wr_data", 32'(data), 32'(e.data));
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_o)     mon_event(EV_WR, wr_addr_o, wr_data_o);
      if (fft_start_o) mon_event(EV_START, 4'h0, 16'h0);
      if (frame_err_o) mon_event(EV_ERR, 4'h0, 16'h0);
    end
  end

  // FFT stand-in: busy follows a start pulse for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (fft_start_o === 1'b1 && busy_len > 0) begin
        fft_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        fft_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit modeled);
    rx_byte  = b;
    rx_valid = 1'b1;
    if (modeled) model_byte(b);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (rx_enable_o && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input int a5_pct);
    for (int i = 0; i < NB; i++)
      pay[i] = (int'($urandom_range(0, 99)) < a5_pct) ? SB : 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame_nowait(input logic [7:0] cx, input int max_gap, input int long_at);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(SB, int'($urandom_range(0, max_gap)), 1'b1);
    for (int i = 0; i < NB; i++) begin
      cs = cs ^ pay[i];
      send_byte(pay[i], (i == long_at) ? TO - 1 : int'($urandom_range(0, max_gap)), 1'b1);
    end
    send_byte(cs ^ cx, 0, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] cx, input int max_gap, input int long_at);
    send_frame_nowait(cx, max_gap, long_at);
    wait_idle();
    check("frame_cnt", 32'(frame_cnt_o), 32'(8'(m_good)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_enable"}, 32'(rx_enable_o), 32'd1);
    check({tag, "_wr_en"},     32'(wr_en_o),     32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr_o),   32'd0);
    check({tag, "_wr_data"},   32'(wr_data_o),   32'd0);
    check({tag, "_fft_start"}, 32'(fft_start_o), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err_o), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] cx;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Counting payload, correct checksum (XOR of 0x00..0x1F is 0x00).
    for (int i = 0; i < NB; i++) pay[i] = 8'(i);
    send_frame(8'h00, 0, -1);
    check("frame_cnt_first", 32'(frame_cnt_o), 32'd1);

    // Same payload, checksum 0x01.
    send_frame(8'h01, 0, -1);
    check("frame_cnt_after_bad", 32'(frame_cnt_o), 32'd1);

    // Garbage before a header.
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'hFF, 1, 1'b1);
    send_byte(8'h5A, 0, 1'b1);
    fill_random(10);
    send_frame(8'h00, 1, -1);

    // Stall after the 7th sample until the timeout fires.
    fill_random(0);
    send_byte(SB, 0, 1'b1);
    for (int i = 0; i < 14; i++) send_byte(pay[i], 0, 1'b1);
    model_timeout();
    lat = -1;
    for (int k = 1; k <= TO + 8; k++) begin
      @(negedge clk); #1;
      if (frame_err_o) begin
        lat = k;
        break;
      end
    end
    check("timeout_latency", 32'(lat), 32'(TO + 1));
    @(posedge clk); #1;
    fill_random(0);
    send_frame(8'h00, 0, -1);

    // A byte landing in the expiry cycle keeps the frame alive.
    fill_random(0);
    send_frame(8'h00, 0, 9);

    // Long FFT run with bytes offered during it.
    busy_len = 100;
    fill_random(0);
    send_frame_nowait(8'h00, 0, -1);
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 20; j++) begin
      check("rx_enable_low_busy", 32'(rx_enable_o), 32'd0);
      send_byte(8'($urandom_range(0, 255)), 2, 1'b0);
    end
    wait_idle();
    check("frame_cnt_busy", 32'(frame_cnt_o), 32'(8'(m_good)));
    busy_len = 5;
    fill_random(0);
    send_frame(8'h00, 0, -1);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      busy_len = int'($urandom_range(0, 20));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        cx = 8'($urandom_range(0, 255));
        if (cx == SB) cx = 8'h00;
        send_byte(cx, int'($urandom_range(0, 2)), 1'b1);
      end
      fill_random(8);
      cx = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      send_frame(cx, int'($urandom_range(0, 3)), -1);
    end

    // Asynchronous reset while in HI of sample 5.
    busy_len = 5;
    fill_random(0);
    send_byte(SB, 0, 1'b1);
    for (int i = 0; i < 11; i++) send_byte(pay[i], 0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    m_in_frame = 1'b0;
    m_good     = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_random(0);
    send_frame(8'h00, 0, -1);
    check("frame_cnt_after_rst", 32'(frame_cnt_o), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
